// File: rtl/mux_21_if.sv
// rtl/mux_21_if.sv - data/select bundle shared by mux_21 and whatever drives it
// The slave side is the mux itself; master is the producer of a/b/control.
interface mux_21_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             control;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             control_q;
    logic [CNT_W-1:0] sel_changes;

    modport master (
        output a,
        output b,
        output control,
        input  y,
        input  y_q,
        input  control_q,
        input  sel_changes
    );

    modport slave (
        input  a,
        input  b,
        input  control,
        output y,
        output y_q,
        output control_q,
        output sel_changes
    );
endinterface

// File: rtl/mux_21.sv
// rtl/mux_21.sv - 2:1 mux with registered copies and a saturating select-change counter
// y is purely combinational and ignores rst; only the registered side is reset.
module mux_21 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    mux_21_if.slave  bus
);
    logic [WIDTH-1:0] y_q_r;
    logic             control_q_r;
    logic [CNT_W-1:0] sel_changes_r;
    logic             sel_changed;
    logic             cnt_full;

    // The ?: form merges a and b bitwise when control is unknown in simulation.
    assign bus.y = bus.control ? bus.b : bus.a;

    assign sel_changed = (bus.control != control_q_r);
    assign cnt_full    = (sel_changes_r == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q_r         <= '0;
            control_q_r   <= 1'b0;
            sel_changes_r <= '0;
        end else begin
            y_q_r       <= bus.y;
            control_q_r <= bus.control;
            if (sel_changed && !cnt_full) begin
                sel_changes_r <= sel_changes_r + CNT_W'(1);
            end
        end
    end

    assign bus.y_q         = y_q_r;
    assign bus.control_q   = control_q_r;
    assign bus.sel_changes = sel_changes_r;
endmodule

// File: tb/tb_mux_21.sv
// tb/tb_mux_21.sv - directed and random checks of mux_21 against a behavioural model
// A second instance with a 2-bit counter exercises saturation.
module tb_mux_21;
    localparam int W   = 32;
    localparam int CW  = 16;
    localparam int CW2 = 2;
    localparam int MAX1 = (1 << CW) - 1;
    localparam int MAX2 = (1 << CW2) - 1;

    logic clk;
    logic rst;

    mux_21_if #(.WIDTH(W), .CNT_W(CW))  m ();
    mux_21_if #(.WIDTH(W), .CNT_W(CW2)) s ();

    mux_21 #(.WIDTH(W), .CNT_W(CW))  dut     (.clk(clk), .rst(rst), .bus(m.slave));
    mux_21 #(.WIDTH(W), .CNT_W(CW2)) dut_sat (.clk(clk), .rst(rst), .bus(s.slave));

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_yq;
    logic         exp_cq;
    int           exp_cnt;
    logic         exp_cq2;
    int           exp_cnt2;

    logic [W-1:0] ta [6];
    logic [W-1:0] tb [6];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return (c == 1'b0) ? a : b;
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    task automatic model_reset();
        exp_yq   = '0;
        exp_cq   = 1'b0;
        exp_cnt  = 0;
        exp_cq2  = 1'b0;
        exp_cnt2 = 0;
    endtask

    task automatic tick();
        if (!rst) begin
            exp_yq = pick(m.a, m.b, m.control);
            if (m.control != exp_cq) exp_cnt = sat_inc(exp_cnt, MAX1);
            exp_cq = m.control;
            if (s.control != exp_cq2) exp_cnt2 = sat_inc(exp_cnt2, MAX2);
            exp_cq2 = s.control;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_yq"},   64'(m.y_q),         64'(exp_yq));
        chk({tag, "_cq"},   64'(m.control_q),   64'(exp_cq));
        chk({tag, "_cnt"},  64'(m.sel_changes), 64'(exp_cnt));
        chk({tag, "_cnt2"}, 64'(s.sel_changes), 64'(exp_cnt2));
    endtask

    task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        m.a = a;
        m.b = b;
        m.control = c;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        m.a = '0; m.b = '0; m.control = 1'b0;
        s.a = '0; s.b = '0; s.control = 1'b0;
        model_reset();

        // Reset takes effect before any clock edge
        #1 rst = 1'b1;
        #1;
        check_regs("reset_async");

        ta[0] = 32'h0000_0000; tb[0] = 32'h0000_0000;
        ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF;
        ta[2] = 32'h0000_0000; tb[2] = 32'hFFFF_FFFF;
        ta[3] = 32'hFFFF_FFFF; tb[3] = 32'h0000_0000;
        ta[4] = 32'h7FFF_FFFF; tb[4] = 32'h8000_0000;
        ta[5] = 32'h1234_5678; tb[5] = 32'h8765_4321;
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 2; c++) begin
                set_in(ta[i], tb[i], c[0]);
                chk($sformatf("comb%0d_c%0d", i, c), 64'(m.y), 64'(c == 0 ? ta[i] : tb[i]));
            end
        end
        check_regs("reset_hold");

        // Leave reset with control=0 so no change is counted
        @(negedge clk);
        set_in(32'h1234_5678, 32'h8765_4321, 1'b0);
        rst = 1'b0;
        tick();
        check_regs("first_load");
        set_in(32'h1234_5678, 32'h8765_4321, 1'b1);
        chk("comb_sel_b", 64'(m.y), 64'h8765_4321);
        tick();
        check_regs("yq_latency");
        chk("yq_prior_y", 64'(m.y_q), 64'h8765_4321);

        // Re-enter reset, leave it with control=1: first edge is a change
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_regs("reset2");
        set_in(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_regs($sformatf("toggle%0d", i));
            set_in(m.a, m.b, ~m.control);
        end
        set_in(m.a, m.b, 1'b1);
        chk("toggle_cnt5", 64'(m.sel_changes), 64'd5);
        chk("toggle_cq_last", 64'(m.control_q), 64'd1);

        // Mid-cycle reset clears registers at once; y keeps tracking
        rst = 1'b1;
        model_reset();
        #1;
        check_regs("mid_reset");
        set_in(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        chk("mid_reset_y_a", 64'(m.y), 64'hDEAD_BEEF);
        set_in(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        chk("mid_reset_y_b", 64'(m.y), 64'h0BAD_F00D);
        tick();
        tick();
        check_regs("mid_reset_hold");

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            set_in($urandom, $urandom, 1'($urandom_range(0, 1)));
            chk($sformatf("rand_y%0d", i), 64'(m.y), 64'(pick(m.a, m.b, m.control)));
            tick();
            check_regs($sformatf("rand%0d", i));
        end

        // Narrow counter: six changes must stop at 3
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_regs("sat_reset");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s.control = ~s.control;
            tick();
            check_regs($sformatf("sat%0d", i));
        end
        chk("sat_value", 64'(s.sel_changes), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) s.control = ~s.control;
            tick();
            chk($sformatf("sat_hold%0d", i), 64'(s.sel_changes), 64'd3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
